// File: rtl/bitonic_merge_pipe_if.sv
// Handshake and lane bus for bitonic_merge_pipe.
// Tag lanes inidx/outidx exist only when BITONIC_MERGE_IDX_EN is defined.
interface bitonic_merge_pipe_if #(
    parameter int width = 8,
    parameter int LOG_N = 5
);
    localparam int N = 1 << LOG_N;

    logic             in_valid;
    logic             in_ready;
    logic             in_dir;
    logic [width-1:0] indata [0:N-1];
    logic             out_valid;
    logic             out_ready;
    logic             out_dir;
    logic [width-1:0] outdata [0:N-1];
    logic             busy;
`ifdef BITONIC_MERGE_IDX_EN
    logic [LOG_N-1:0] inidx  [0:N-1];
    logic [LOG_N-1:0] outidx [0:N-1];
`endif

    modport master (
`ifdef BITONIC_MERGE_IDX_EN
        output inidx,
        input  outidx,
`endif
        output in_valid, in_dir, indata, out_ready,
        input  in_ready, out_valid, out_dir, outdata, busy
    );

    modport slave (
`ifdef BITONIC_MERGE_IDX_EN
        input  inidx,
        output outidx,
`endif
        input  in_valid, in_dir, indata, out_ready,
        output in_ready, out_valid, out_dir, outdata, busy
    );
endinterface

// File: rtl/bitonic_merge_pipe.sv
// Pipelined bitonic merge network: one compare-exchange rank per registered stage, valid/ready with bubble collapsing.
// Optional BITONIC_MERGE_IDX_EN: per-lane index tags travel with values and ties resolve by smaller tag (stable merge).
module bitonic_merge_pipe #(
    parameter int width = 8,
    parameter int LOG_N = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    bitonic_merge_pipe_if.slave  bus
);
    localparam int N = 1 << LOG_N;

    logic [width-1:0] data_q  [0:LOG_N-1][0:N-1];
    logic [width-1:0] stg_in  [0:LOG_N-1][0:N-1];
    logic [width-1:0] stg_out [0:LOG_N-1][0:N-1];
    logic [LOG_N-1:0] v_q;
    logic [LOG_N-1:0] dir_q;
    logic [LOG_N-1:0] vin;
    logic [LOG_N-1:0] dir_in;
    logic [LOG_N:0]   en;
`ifdef BITONIC_MERGE_IDX_EN
    logic [LOG_N-1:0] idx_q   [0:LOG_N-1][0:N-1];
    logic [LOG_N-1:0] idx_in  [0:LOG_N-1][0:N-1];
    logic [LOG_N-1:0] idx_out [0:LOG_N-1][0:N-1];
`endif

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        en        = '0;
        en[LOG_N] = bus.out_ready;
        for (int s = LOG_N - 1; s >= 0; s--) begin
            en[s] = ~v_q[s] | en[s+1];
        end
    end

    always_comb begin
        vin[0]    = bus.in_valid;
        dir_in[0] = bus.in_dir;
        for (int k = 0; k < N; k++) begin
            stg_in[0][k] = bus.indata[k];
`ifdef BITONIC_MERGE_IDX_EN
            idx_in[0][k] = bus.inidx[k];
`endif
        end
        for (int s = 1; s < LOG_N; s++) begin
            vin[s]    = v_q[s-1];
            dir_in[s] = dir_q[s-1];
            for (int k = 0; k < N; k++) begin
                stg_in[s][k] = data_q[s-1][k];
`ifdef BITONIC_MERGE_IDX_EN
                idx_in[s][k] = idx_q[s-1][k];
`endif
            end
        end
    end

    // Pair index i is built from j by inserting a zero at bit position log2(d).
    always_comb begin
        int   d;
        int   i;
        logic swap;
        d    = 0;
        i    = 0;
        swap = 1'b0;
        for (int s = 0; s < LOG_N; s++) begin
            for (int k = 0; k < N; k++) begin
                stg_out[s][k] = stg_in[s][k];
`ifdef BITONIC_MERGE_IDX_EN
                idx_out[s][k] = idx_in[s][k];
`endif
            end
        end
        for (int s = 0; s < LOG_N; s++) begin
            d = N >> (s + 1);
            for (int j = 0; j < N / 2; j++) begin
                i    = ((j & ~(d - 1)) << 1) | (j & (d - 1));
                swap = dir_in[s] ? (stg_in[s][i] > stg_in[s][i+d])
                                 : (stg_in[s][i] < stg_in[s][i+d]);
`ifdef BITONIC_MERGE_IDX_EN
                if ((stg_in[s][i] == stg_in[s][i+d]) && (idx_in[s][i] > idx_in[s][i+d]))
                    swap = 1'b1;
`endif
                if (swap) begin
                    stg_out[s][i]   = stg_in[s][i+d];
                    stg_out[s][i+d] = stg_in[s][i];
`ifdef BITONIC_MERGE_IDX_EN
                    idx_out[s][i]   = idx_in[s][i+d];
                    idx_out[s][i+d] = idx_in[s][i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            dir_q <= '0;
            for (int s = 0; s < LOG_N; s++) begin
                for (int k = 0; k < N; k++) begin
                    data_q[s][k] <= '0;
`ifdef BITONIC_MERGE_IDX_EN
                    idx_q[s][k]  <= '0;
`endif
                end
            end
        end else begin
            for (int s = 0; s < LOG_N; s++) begin
                if (en[s]) begin
                    v_q[s] <= vin[s];
                    if (vin[s]) begin
                        dir_q[s] <= dir_in[s];
                        for (int k = 0; k < N; k++) begin
                            data_q[s][k] <= stg_out[s][k];
`ifdef BITONIC_MERGE_IDX_EN
                            idx_q[s][k]  <= idx_out[s][k];
`endif
                        end
                    end
                end
            end
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v_q[LOG_N-1];
    assign bus.out_dir   = dir_q[LOG_N-1];
    assign bus.busy      = |v_q;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.outdata[k] = data_q[LOG_N-1][k];
`ifdef BITONIC_MERGE_IDX_EN
            bus.outidx[k]  = idx_q[LOG_N-1][k];
`endif
        end
    end
endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Scoreboard bench for bitonic_merge_pipe (LOG_N=3, width=8) with directed, hand-sorted vectors.
// Tag checks run only when BITONIC_MERGE_IDX_EN is defined.
module tb_bitonic_merge_pipe;
    localparam int W  = 8;
    localparam int LG = 3;
    localparam int NL = 8;

    typedef logic [0:NL-1][W-1:0]  vec_t;
    typedef logic [0:NL-1][LG-1:0] tag_t;
    typedef struct packed {
        vec_t        d;
        logic        dir;
        tag_t        idx;
        logic        chk_idx;
        logic        exact;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bitonic_merge_pipe_if #(.width(W), .LOG_N(LG)) bus ();
    bitonic_merge_pipe #(.width(W), .LOG_N(LG)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input vec_t d, input logic dir, input tag_t idx,
                                input logic chk_idx, input logic exact);
        exp_t e;
        e.d       = d;
        e.dir     = dir;
        e.idx     = idx;
        e.chk_idx = chk_idx;
        e.exact   = exact;
        e.acc     = '0;
        return e;
    endfunction

    // Monitor: compares whatever the last stage presents against the head of the queue.
    exp_t e_m;
    vec_t act_d;
    tag_t act_i;
    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got out_valid=1, required no pending result");
            end else begin
                e_m = q[0];
                for (int k = 0; k < NL; k++) act_d[k] = bus.outdata[k];
                check("outdata", 64'(act_d), 64'(e_m.d));
                check("out_dir", 64'(bus.out_dir), 64'(e_m.dir));
`ifdef BITONIC_MERGE_IDX_EN
                for (int k = 0; k < NL; k++) act_i[k] = bus.outidx[k];
                if (e_m.chk_idx) check("outidx", 64'(act_i), 64'(e_m.idx));
`else
                act_i = '0;
`endif
                if (bus.out_ready) begin
                    if (e_m.exact) check("latency", 64'(cyc - int'(e_m.acc)), 64'(LG));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Caller must be at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input logic dir, input tag_t idx, input exp_t e,
                        input logic push, output int waits);
        bus.in_valid = 1'b1;
        bus.in_dir   = dir;
        for (int k = 0; k < NL; k++) begin
            bus.indata[k] = v[k];
`ifdef BITONIC_MERGE_IDX_EN
            bus.inidx[k]  = idx[k];
`endif
        end
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waits);
        end else if (push) begin
            e.acc = 32'(cyc);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check(name, 64'(q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        vec_t z;
        for (int k = 0; k < NL; k++) z[k] = bus.outdata[k];
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_busy"},      64'(bus.busy),      64'd0);
        check({name, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({name, "_outdata"},   64'(z),             64'd0);
        check({name, "_out_dir"},   64'(bus.out_dir),   64'd0);
    endtask

    vec_t v1, v1_desc, v1_asc, va, vb, vc, vd, ve, vf, ea, eb, ec, ed, ee, ef, v5;
    tag_t id, v1_tags;
    int   w;
    bit   saw_low;
    int   t0;

    initial begin
        v1      = {8'd1, 8'd4, 8'd6, 8'd8, 8'd7, 8'd5, 8'd3, 8'd2};
        v1_desc = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        v1_asc  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        va = {8'd10, 8'd20, 8'd30, 8'd40, 8'd35, 8'd25, 8'd15, 8'd5};
        ea = {8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd35, 8'd40};
        vb = {8'd9, 8'd7, 8'd3, 8'd0, 8'd2, 8'd4, 8'd6, 8'd8};
        eb = {8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2, 8'd0};
        vc = {8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
        ec = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
        vd = {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        ed = vd;
        ve = {8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30};
        ee = {8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
        vf = v1_asc;
        ef = v1_desc;
        v5 = {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        id      = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        v1_tags = {3'd3, 3'd4, 3'd2, 3'd5, 3'd1, 3'd6, 3'd7, 3'd0};

        // Reset held with in_valid asserted.
        bus.in_valid  = 1'b1;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < NL; k++) begin
            bus.indata[k] = v1[k];
`ifdef BITONIC_MERGE_IDX_EN
            bus.inidx[k]  = id[k];
`endif
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First accept on the first edge after release, then back-to-back directions.
        send(v1, 1'b0, id, mk(v1_desc, 1'b0, id, 1'b0, 1'b1), 1'b1, w);
        check("first_accept_waits", 64'(w), 64'd0);
        send(v1, 1'b1, id, mk(v1_asc,  1'b1, id, 1'b0, 1'b1), 1'b1, w);
        send(v1, 1'b0, id, mk(v1_desc, 1'b0, id, 1'b0, 1'b1), 1'b1, w);
        drain("drain_basic");

        // Six vectors streamed with out_ready low for relative cycles 4..7.
        t0      = cyc;
        saw_low = 1'b0;
        fork
            begin
                send(va, 1'b1, id, mk(ea, 1'b1, id, 1'b0, 1'b1), 1'b1, w);
                send(vb, 1'b0, id, mk(eb, 1'b0, id, 1'b0, 1'b0), 1'b1, w);
                send(vc, 1'b1, id, mk(ec, 1'b1, id, 1'b0, 1'b0), 1'b1, w);
                send(vd, 1'b0, id, mk(ed, 1'b0, id, 1'b0, 1'b0), 1'b1, w);
                send(ve, 1'b1, id, mk(ee, 1'b1, id, 1'b0, 1'b0), 1'b1, w);
                send(vf, 1'b0, id, mk(ef, 1'b0, id, 1'b0, 1'b0), 1'b1, w);
                bus.in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    bus.out_ready = !((cyc - t0) >= 4 && (cyc - t0) <= 7);
                    @(negedge clk);
                    if (!bus.in_ready) saw_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        check("in_ready_dropped_when_full", 64'(saw_low), 64'd1);
        drain("drain_stall");

`ifdef BITONIC_MERGE_IDX_EN
        send(v5, 1'b0, id, mk(v5, 1'b0, id, 1'b1, 1'b1), 1'b1, w);
        send(v1, 1'b0, id, mk(v1_desc, 1'b0, v1_tags, 1'b1, 1'b1), 1'b1, w);
        drain("drain_idx");
`endif

        // Two vectors in flight when reset hits; they must never appear.
        send(va, 1'b1, id, mk(ea, 1'b1, id, 1'b0, 1'b0), 1'b0, w);
        send(vb, 1'b0, id, mk(eb, 1'b0, id, 1'b0, 1'b0), 1'b0, w);
        bus.in_valid = 1'b0;
        #2;
        check("busy_before_reset", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("busy_after_discard", 64'(bus.busy), 64'd0);

        send(vc, 1'b1, id, mk(ec, 1'b1, id, 1'b0, 1'b1), 1'b1, w);
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
